// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// The stall timeout is built only when UART_ARB_TIMEOUT_EN is defined.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_DATA_BITS      = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Increment with wrap at n, used to advance the round-robin pointer.
  function automatic int wrap_inc(int v, int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first set request at or after ptr
// (wrapping) wins; the result is one-hot, or all-zero with no requests.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_oh;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot    = NUM_REQ'({req, req} >> ptr);
    rot_oh = rot & (~rot + NUM_REQ'(1));
    winner = NUM_REQ'(({rot_oh, rot_oh} << ptr) >> NUM_REQ);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX holding register.
// Define UART_ARB_TIMEOUT_EN to add the mid-packet stall timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ*DATA_BITS-1:0]  reqData,
  input  logic [NUM_REQ-1:0]            reqLast,
  output logic [NUM_REQ-1:0]            reqReady,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          fifoWrite,
  output logic [DATA_BITS-1:0]          fifoWData,
  input  logic                          txFull,
  output logic                          busy,
`ifdef UART_ARB_TIMEOUT_EN
  output logic                          timeoutErr,
  input  logic                          errClear,
`endif
  output arb_state_e                    dbg_state,
  output logic [$clog2(NUM_REQ)-1:0]    dbg_rr_ptr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   next_ptr;
  logic               last_q;

  logic [NUM_REQ-1:0]   winner;
  logic [IDX_W-1:0]     win_idx;
  logic [DATA_BITS-1:0] sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 accept;
  logic                 timeout_hit;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (IDX_W)
  ) u_picker (
    .req    (reqValid),
    .ptr    (rr_ptr_q),
    .winner (winner)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = IDX_W'(i);
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) sel_data = reqData[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign sel_valid = |(grant_q & reqValid);
  assign sel_last  = |(grant_q & reqLast);
  assign next_ptr  = IDX_W'(wrap_inc(32'(owner_q), NUM_REQ));

  // Handshake: a byte moves when reqValid[i] & reqReady[i]; ready is only
  // offered to the owner in SEND with room in the holding register, and
  // that same cycle is the fifoWrite strobe.
  assign reqReady  = (state_q == ST_SEND && !txFull) ? grant_q : '0;
  assign accept    = |(reqReady & reqValid);
  assign fifoWrite = accept;
  assign fifoWData = accept ? sel_data : '0;

  assign grant      = grant_q;
  assign busy       = |grant_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

  // HOLD after every accept gives txFull one cycle to reflect the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|reqValid) begin
            grant_q <= winner;
            owner_q <= win_idx;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (accept) begin
            last_q  <= sel_last;
            state_q <= ST_HOLD;
          end else if (timeout_hit) begin
            grant_q  <= '0;
            rr_ptr_q <= next_ptr;
            state_q  <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (last_q) begin
            grant_q  <= '0;
            rr_ptr_q <= next_ptr;
            state_q  <= ST_IDLE;
          end else begin
            state_q <= ST_SEND;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] stall_cnt_q;
  logic             timeout_err_q;
  logic             stall;

  // Only an owner that is silent while the UART has room counts as stalled.
  assign stall       = (state_q == ST_SEND) && !txFull && !sel_valid;
  assign timeout_hit = stall && (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeoutErr  = timeout_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (accept || timeout_hit) begin
        stall_cnt_q <= '0;
      end else if (stall) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end else if (errClear) begin
        timeout_err_q <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a write scoreboard; the stall
// timeout scenario runs only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(NUM_REQ);
  localparam int W         = NUM_REQ + DATA_BITS;

  logic                         clk;
  logic                         reset;
  logic [NUM_REQ-1:0]           reqValid;
  logic [NUM_REQ*DATA_BITS-1:0] reqData;
  logic [NUM_REQ-1:0]           reqLast;
  logic [NUM_REQ-1:0]           reqReady;
  logic [NUM_REQ-1:0]           grant;
  logic                         fifoWrite;
  logic [DATA_BITS-1:0]         fifoWData;
  logic                         txFull;
  logic                         busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic                         timeoutErr;
  logic                         errClear;
`endif
  arb_state_e                   dbg_state;
  logic [IDX_W-1:0]             dbg_rr_ptr;

  logic [DATA_BITS:0]   drv_q [NUM_REQ][$];
  logic [W-1:0]         exp_q [$];
  int unsigned          wr_cyc [$];
  int unsigned          cyc_cnt;
  logic [NUM_REQ-1:0]   acc;
  int                   n_cmp;
  int                   n_fail;

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .DATA_BITS      (DATA_BITS),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .reqValid   (reqValid),
    .reqData    (reqData),
    .reqLast    (reqLast),
    .reqReady   (reqReady),
    .grant      (grant),
    .fifoWrite  (fifoWrite),
    .fifoWData  (fifoWData),
    .txFull     (txFull),
    .busy       (busy),
`ifdef UART_ARB_TIMEOUT_EN
    .timeoutErr (timeoutErr),
    .errClear   (errClear),
`endif
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: present each requester's queue head, pop on a handshake
  task automatic refresh();
    logic [DATA_BITS:0] e;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (drv_q[i].size() != 0) begin
        e = drv_q[i][0];
        reqValid[i] = 1'b1;
        reqLast[i]  = e[DATA_BITS];
        reqData[i*DATA_BITS +: DATA_BITS] = e[DATA_BITS-1:0];
      end else begin
        reqValid[i] = 1'b0;
        reqLast[i]  = 1'b0;
        reqData[i*DATA_BITS +: DATA_BITS] = '0;
      end
    end
  endtask

  task automatic push_byte(int r, logic [DATA_BITS-1:0] d, logic last);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    drv_q[r].push_back({last, d});
    exp_q.push_back({oh, d});
  endtask

  always begin
    @(negedge clk);
    acc = reqValid & reqReady;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i] && drv_q[i].size() != 0) void'(drv_q[i].pop_front());
    end
    refresh();
  end

  // Scoreboard: every write must match the next expected {grant, byte}
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset === 1'b0 && fifoWrite === 1'b1) begin
      wr_cyc.push_back(cyc_cnt);
      n_cmp++;
      if (exp_q.size() == 0) begin
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected_write: observed grant %0h data %0h expected no write",
                 grant, fifoWData);
        end
      end else begin
        e = exp_q.pop_front();
        assert ({grant, fifoWData} === e) else begin
          n_fail++;
          $error("FAIL sb_write: observed grant %0h data %0h expected grant %0h data %0h",
                 grant, fifoWData, e[W-1:DATA_BITS], e[DATA_BITS-1:0]);
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(string tag, int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0 || dbg_state !== ST_IDLE) && k < budget) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(k < budget), 32'd1);
  endtask

  initial begin
    int k;
    n_cmp    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    txFull   = 1'b0;
    reqValid = '0;
    reqData  = '0;
    reqLast  = '0;
`ifdef UART_ARB_TIMEOUT_EN
    errClear = 1'b0;
`endif
    cyc(3);

    // Reset state
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(reqReady), 32'h0);
    chk("rst_fifo_write", 32'(fifoWrite), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_rr_ptr", 32'(dbg_rr_ptr), 32'h0);
`ifdef UART_ARB_TIMEOUT_EN
    chk("rst_timeout_err", 32'(timeoutErr), 32'h0);
`endif
    reset = 1'b0;
    cyc(2);

    // Single 3-byte packet from req0: one byte per two cycles
    wr_cyc.delete();
    push_byte(0, 8'h11, 1'b0);
    push_byte(0, 8'h22, 1'b0);
    push_byte(0, 8'h33, 1'b1);
    refresh();
    chk("p0_grant_delay", 32'(busy), 32'h0);
    cyc(1);
    chk("p0_grant", 32'(grant), 32'h1);
    chk("p0_state_send", 32'(dbg_state), 32'(ST_SEND));
    wait_drain("p0_drain", 30);
    chk("p0_rr_ptr", 32'(dbg_rr_ptr), 32'h1);
    chk("p0_writes", wr_cyc.size(), 32'd3);
    if (wr_cyc.size() == 3) begin
      chk("p0_gap1", wr_cyc[1] - wr_cyc[0], 32'd2);
      chk("p0_gap2", wr_cyc[2] - wr_cyc[1], 32'd2);
    end

    // txFull back-pressure for 20 cycles on req2's packet
    push_byte(2, 8'hA1, 1'b0);
    push_byte(2, 8'hA2, 1'b1);
    refresh();
    cyc(1);
    txFull = 1'b1;
    wr_cyc.delete();
    chk("bp_grant", 32'(grant), 32'h4);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("bp_ready", 32'(reqReady), 32'h0);
      chk("bp_fifo_write", 32'(fifoWrite), 32'h0);
      chk("bp_grant_stable", 32'(grant), 32'h4);
    end
    chk("bp_state", 32'(dbg_state), 32'(ST_SEND));
    chk("bp_no_writes", wr_cyc.size(), 32'd0);
    txFull = 1'b0;
    #1;
    chk("bp_resume_write", 32'(fifoWrite), 32'h1);
    chk("bp_resume_ready", 32'(reqReady), 32'h4);
    wait_drain("bp_drain", 30);
    chk("bp_rr_ptr", 32'(dbg_rr_ptr), 32'h3);

    // req3 alone brings the pointer back to 0
    push_byte(3, 8'hC3, 1'b1);
    refresh();
    cyc(1);
    chk("r3_grant", 32'(grant), 32'h8);
    wait_drain("r3_drain", 30);
    chk("r3_rr_ptr", 32'(dbg_rr_ptr), 32'h0);

    // req1 and req2 together: req1 packet completes before any req2 byte
    wr_cyc.delete();
    push_byte(1, 8'hB1, 1'b0);
    push_byte(1, 8'hB2, 1'b1);
    push_byte(2, 8'hD1, 1'b0);
    push_byte(2, 8'hD2, 1'b1);
    refresh();
    cyc(1);
    chk("rr_first_grant", 32'(grant), 32'h2);
    wait_drain("rr_drain", 40);
    chk("rr_writes", wr_cyc.size(), 32'd4);
    if (wr_cyc.size() == 4) begin
      chk("rr_gap_in_pkt", wr_cyc[1] - wr_cyc[0], 32'd2);
      chk("rr_gap_between", wr_cyc[2] - wr_cyc[1], 32'd3);
    end
    chk("rr_rr_ptr", 32'(dbg_rr_ptr), 32'h3);

`ifdef UART_ARB_TIMEOUT_EN
    // Owner goes silent mid-packet: forced end after 16 stall cycles
    wr_cyc.delete();
    push_byte(0, 8'hE1, 1'b0);
    refresh();
    cyc(1);
    chk("to_grant", 32'(grant), 32'h1);
    wait_drain("to_drain", 40);
    if (wr_cyc.size() == 1) chk("to_latency", cyc_cnt - wr_cyc[0], 32'd18);
    else chk("to_writes", wr_cyc.size(), 32'd1);
    chk("to_err_set", 32'(timeoutErr), 32'h1);
    chk("to_rr_ptr", 32'(dbg_rr_ptr), 32'h1);
    errClear = 1'b1;
    cyc(1);
    errClear = 1'b0;
    chk("to_err_clear", 32'(timeoutErr), 32'h0);
`endif

    // Reset in HOLD abandons the packet and restarts arbitration from 0
    push_byte(1, 8'h51, 1'b0);
    push_byte(1, 8'h52, 1'b0);
    push_byte(1, 8'h53, 1'b1);
    refresh();
    k = 0;
    while (dbg_state !== ST_HOLD && k < 20) begin
      cyc(1);
      k++;
    end
    chk("mr_reach_hold", 32'(k < 20), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_ready", 32'(reqReady), 32'h0);
    chk("mr_fifo_write", 32'(fifoWrite), 32'h0);
    chk("mr_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mr_rr_ptr", 32'(dbg_rr_ptr), 32'h0);
    for (int i = 0; i < NUM_REQ; i++) drv_q[i].delete();
    exp_q.delete();
    refresh();
    cyc(2);
    reset = 1'b0;
    cyc(2);
    chk("mr_post_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mr_post_write", 32'(fifoWrite), 32'h0);
    push_byte(0, 8'h61, 1'b1);
    push_byte(3, 8'h71, 1'b1);
    refresh();
    cyc(1);
    chk("mr_rearb_grant", 32'(grant), 32'h1);
    wait_drain("mr_drain", 30);
    chk("mr_final_rr_ptr", 32'(dbg_rr_ptr), 32'h0);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
